// File: rtl/period_meter.sv
// period_meter: measures the rising-edge to rising-edge distance of a slow asynchronous input in clk cycles.
// Optional min/max period statistics are built when PERIOD_METER_MINMAX_EN is defined.
module period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             timeout,
    output logic             busy,
    output logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] max_period
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] MEASURE    = 2'd1;
    localparam logic [1:0] TIMEOUT_ST = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;
    logic                   rise;
    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   update;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev   <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev;

    // A rise landing on a saturated count restarts measurement but is not
    // reported, so only periods up to CNT_MAX-1 ever produce a valid strobe.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        update    = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_nxt = MEASURE;
                        cnt_nxt   = CNT_ONE;
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        cnt_nxt = CNT_ONE;
                        update  = (cnt != CNT_MAX);
                    end else if (cnt == CNT_MAX) begin
                        state_nxt = TIMEOUT_ST;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                TIMEOUT_ST: begin
                    if (rise) begin
                        state_nxt = MEASURE;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            period  <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            valid   <= update;
            busy    <= (state_nxt == MEASURE);
            timeout <= (state_nxt == TIMEOUT_ST);
            if (update) begin
                period <= cnt;
            end
        end
    end

`ifdef PERIOD_METER_MINMAX_EN
    logic [CNT_W-1:0] min_q;
    logic [CNT_W-1:0] max_q;

    // A period update coinciding with a clear seeds both statistics with that period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_q <= '1;
            max_q <= '0;
        end else if (update) begin
            if (clr_stats) begin
                min_q <= cnt;
                max_q <= cnt;
            end else begin
                if (cnt < min_q) begin
                    min_q <= cnt;
                end
                if (cnt > max_q) begin
                    max_q <= cnt;
                end
            end
        end else if (clr_stats) begin
            min_q <= '1;
            max_q <= '0;
        end
    end

    assign min_period = min_q;
    assign max_period = max_q;
`else
    logic unused_clr;

    assign unused_clr = clr_stats;
    assign min_period = '0;
    assign max_period = '0;
`endif

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: drives edge trains into period_meter and checks reported periods against an edge-time model.
// Build with PERIOD_METER_MINMAX_EN defined to also check the min/max statistics.
module tb_period_meter;

    localparam int CNT_W = 6;
    localparam int SYNC  = 2;
    localparam int MAX   = (1 << CNT_W) - 1;
    localparam int LAT   = SYNC + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             sig_in = 1'b0;
    logic             clr_stats = 1'b0;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             timeout;
    logic             busy;
    logic [CNT_W-1:0] min_period;
    logic [CNT_W-1:0] max_period;

    always #5 clk = ~clk;

    period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sig_in     (sig_in),
        .clr_stats  (clr_stats),
        .period     (period),
        .valid      (valid),
        .timeout    (timeout),
        .busy       (busy),
        .min_period (min_period),
        .max_period (max_period)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int got_cyc[$];
    int got_per[$];
    int exp_cyc[$];
    int exp_per[$];
    int plan[$];

    bit model_en   = 1'b0;
    bit have_prev  = 1'b0;
    int prev_c     = 0;
    int last_per   = 0;
    int mdl_min    = MAX;
    int mdl_max    = 0;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            got_cyc.push_back(cyc);
            got_per.push_back(int'(period));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int exp_min();
`ifdef PERIOD_METER_MINMAX_EN
        return mdl_min;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_max();
`ifdef PERIOD_METER_MINMAX_EN
        return mdl_max;
`else
        return 0;
`endif
    endfunction

    // Reference model: a period is the distance between consecutive driven rising edges.
    task automatic model_rise(input int c);
        int gap;
        if (!model_en) return;
        if (have_prev) begin
            gap = c - prev_c;
            if (gap >= 2 && gap <= MAX - 1) begin
                exp_cyc.push_back(c + LAT);
                exp_per.push_back(gap);
                last_per = gap;
                if (gap < mdl_min) mdl_min = gap;
                if (gap > mdl_max) mdl_max = gap;
            end
        end
        prev_c    = c;
        have_prev = 1'b1;
    endtask

    task automatic model_reset();
        have_prev = 1'b0;
        last_per  = 0;
        mdl_min   = MAX;
        mdl_max   = 0;
    endtask

    task automatic drive(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            if (b && !sig_in) model_rise(cyc);
            sig_in = b;
            tick();
        end
    endtask

    task automatic applyStimulus();
        int p;
        int h;
        foreach (plan[i]) begin
            p = plan[i];
            h = int'($urandom_range(p - 1, 1));
            drive(1'b1, h);
            drive(1'b0, p - h);
        end
        drive(1'b1, 1);
    endtask

    task automatic checkOutput(input string tag);
        int n;
        drive(1'b0, LAT + 3);
        check({tag, "_count"}, got_per.size(), exp_per.size());
        n = (got_per.size() < exp_per.size()) ? got_per.size() : exp_per.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_period"}, got_per[i], exp_per[i]);
            check({tag, "_valid_cyc"}, got_cyc[i], exp_cyc[i]);
        end
        check({tag, "_min"}, 32'(min_period), exp_min());
        check({tag, "_max"}, 32'(max_period), exp_max());
        got_cyc.delete();
        got_per.delete();
        exp_cyc.delete();
        exp_per.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_period"}, 32'(period), last_per);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_timeout"}, 32'(timeout), 0);
        check({tag, "_min"}, 32'(min_period), exp_min());
        check({tag, "_max"}, 32'(max_period), exp_max());
    endtask

    initial begin
        // Power-on reset
        #1 rst = 1'b0;
        #1;
        model_reset();
        check_idle_outputs("reset");
        tick();
        tick();
        rst = 1'b1;
        en = 1'b1;
        model_en = 1'b1;
        drive(1'b0, 4);

        // Square wave of period 8
        plan.delete();
        repeat (8) plan.push_back(8);
        applyStimulus();
        check("sq8_busy", 32'(busy), 1);
        check("sq8_timeout", 32'(timeout), 0);
        checkOutput("sq8");

        // Fastest input: toggles every clk
        plan.delete();
        repeat (10) plan.push_back(2);
        applyStimulus();
        checkOutput("p2");

        // Random periods
        plan.delete();
        repeat (12) plan.push_back(int'($urandom_range(60, 2)));
        applyStimulus();
        checkOutput("rand");

        // Saturation boundary: gap MAX is never reported, gap MAX-1 is
        drive(1'b1, 1);
        drive(1'b0, MAX - 1);
        drive(1'b1, 1);
        drive(1'b0, MAX - 2);
        drive(1'b1, 1);
        check("edge_max_timeout", 32'(timeout), 0);
        checkOutput("edge_max");

        // Timeout after a lone edge, then recovery
        drive(1'b1, 1);
        drive(1'b0, MAX + 1);
        check("to_before", 32'(timeout), 0);
        drive(1'b0, 1);
        check("to_set", 32'(timeout), 1);
        check("to_busy", 32'(busy), 0);
        drive(1'b0, 10);
        check("to_hold", 32'(timeout), 1);
        check("to_period", 32'(period), last_per);
        plan.delete();
        repeat (3) plan.push_back(5);
        applyStimulus();
        check("to_clear", 32'(timeout), 0);
        check("to_rec_busy", 32'(busy), 1);
        checkOutput("to_rec");

        // Enable dropped mid-period
        drive(1'b1, 1);
        drive(1'b0, 5);
        en = 1'b0;
        model_en = 1'b0;
        have_prev = 1'b0;
        drive(1'b0, 1);
        check_idle_outputs("endrop");
        drive(1'b1, 2);
        drive(1'b0, 6);
        check("endrop_ign_busy", 32'(busy), 0);
        en = 1'b1;
        model_en = 1'b1;
        drive(1'b0, 2);
        plan.delete();
        plan.push_back(9);
        plan.push_back(12);
        applyStimulus();
        checkOutput("reen");

        // Reset mid-measurement
        drive(1'b1, 1);
        drive(1'b0, 4);
        rst = 1'b0;
        #1;
        model_reset();
        check_idle_outputs("midrst");
        got_cyc.delete();
        got_per.delete();
        exp_cyc.delete();
        exp_per.delete();
        tick();
        tick();
        rst = 1'b1;
        drive(1'b0, 3);
        plan.delete();
        plan.push_back(6);
        plan.push_back(10);
        plan.push_back(8);
        applyStimulus();
        checkOutput("stats");

        // Statistics clear, then a single new period
        en = 1'b0;
        model_en = 1'b0;
        have_prev = 1'b0;
        drive(1'b0, 2);
        clr_stats = 1'b1;
        drive(1'b0, 1);
        clr_stats = 1'b0;
`ifdef PERIOD_METER_MINMAX_EN
        mdl_min = MAX;
        mdl_max = 0;
`endif
        check("clr_min", 32'(min_period), exp_min());
        check("clr_max", 32'(max_period), exp_max());
        en = 1'b1;
        model_en = 1'b1;
        drive(1'b0, 2);
        plan.delete();
        plan.push_back(7);
        applyStimulus();
        checkOutput("post_clr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
